// File: rtl/rdcla_arb_pkg.sv
// Shared definitions for the RDCLA32 round-robin arbiter.
//
// Contents:
//   W_DEFAULT     default operand/sum width (matches the RDCLA32 adder)
//   NREQ_DEFAULT  default requester count
//   NREQ_MAX      largest supported requester count
//   id_width()    index width needed to name one of n requesters (min 1)
//   IDW           requester-ID width carried in a tag
//   tag_t         in-flight tag {valid, id}
package rdcla_arb_pkg;

    localparam int W_DEFAULT    = 32;
    localparam int NREQ_DEFAULT = 4;
    localparam int NREQ_MAX     = 8;

    // Width of an index into n requesters; never below one bit so that the
    // pointer and ID fields stay legal vectors for tiny configurations.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // The tag ID is sized for the largest supported requester count so one
    // tag type serves every configuration of the arbiter.
    localparam int IDW = id_width(NREQ_MAX);

    typedef struct packed {
        logic           valid;
        logic [IDW-1:0] id;
    } tag_t;

endpackage

// File: rtl/rdcla_arbiter_rr_grant.sv
// Combinational round-robin picker.
//
// Scans the request vector starting at ptr and wrapping modulo NREQ; the
// first asserted request wins.
//
// Ports:
//   req    in   NREQ  request vector
//   ptr    in   PTRW  highest-priority index for this cycle
//   grant  out  NREQ  one-hot grant (all zero when nothing is requested)
//   idx    out  PTRW  encoded index of the granted requester
//   any    out  1     at least one request is asserted
module rr_grant #(
    parameter int NREQ = 4,
    parameter int PTRW = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PTRW-1:0] ptr,
    output logic [NREQ-1:0] grant,
    output logic [PTRW-1:0] idx,
    output logic            any
);

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = (int'(ptr) + k) % NREQ;
            // Once a winner is found, later positions in the search order
            // are ignored.
            if (!any && req[j]) begin
                grant[j] = 1'b1;
                idx      = PTRW'(j);
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rdcla_arbiter.sv
// Round-robin arbiter sharing one registered carry-lookahead adder among
// NREQ requesters. One request is granted per cycle; its operands are steered
// to the adder, and a {valid, id} tag follows the operation through a tag
// pipe matched to the adder latency so the result can be routed back.
//
// Parameters:
//   W     operand/sum width (must match the adder)
//   NREQ  number of requesters (2..8)
//   LAT   adder latency in clock edges (>= 1)
//
// Ports:
//   clk        in   1       rising-edge clock
//   rst_n      in   1       asynchronous active-low reset
//   req_valid  in   NREQ    per-requester request valid
//   req_ready  out  NREQ    one-hot grant (handshake = valid & ready)
//   req_a      in   NREQ*W  operand A, requester i at [i*W +: W]
//   req_b      in   NREQ*W  operand B, same packing
//   req_cin    in   NREQ    per-requester carry-in
//   rsp_valid  out  NREQ    one-hot result-valid
//   rsp_sum    out  W       shared result sum
//   rsp_cout   out  1       shared result carry-out
//   add_in1    out  W       adder operand 1
//   add_in2    out  W       adder operand 2
//   add_cin    out  1       adder carry-in
//   add_sum    in   W       adder sum
//   add_cout   in   1       adder carry-out
module rdcla_arbiter
    import rdcla_arb_pkg::*;
#(
    parameter int W    = W_DEFAULT,
    parameter int NREQ = NREQ_DEFAULT,
    parameter int LAT  = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    input  logic [NREQ-1:0]   req_cin,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [W-1:0]      rsp_sum,
    output logic              rsp_cout,
    output logic [W-1:0]      add_in1,
    output logic [W-1:0]      add_in2,
    output logic              add_cin,
    input  logic [W-1:0]      add_sum,
    input  logic              add_cout
);

    localparam int PTRW = id_width(NREQ);

    logic [PTRW-1:0] ptr_reg;
    logic [PTRW-1:0] ptr_next;

    logic [NREQ-1:0] grant_raw;
    logic [PTRW-1:0] grant_idx;
    logic            grant_any_raw;
    logic            grant_any;

    tag_t            tag_next;
    tag_t            tag_reg [LAT];
    tag_t            tag_tail;

    // ------------------------------------------------------------------
    // Grant selection
    // ------------------------------------------------------------------
    rr_grant #(
        .NREQ (NREQ),
        .PTRW (PTRW)
    ) u_rr_grant (
        .req   (req_valid),
        .ptr   (ptr_reg),
        .grant (grant_raw),
        .idx   (grant_idx),
        .any   (grant_any_raw)
    );

    // While reset is held no handshake may complete, so the grant is gated
    // by rst_n itself rather than waiting for a register to clear.
    assign grant_any = grant_any_raw & rst_n;
    assign req_ready = grant_raw & {NREQ{rst_n}};

    // ------------------------------------------------------------------
    // Operand mux: granted requester's operands, zero when idle
    // ------------------------------------------------------------------
    always_comb begin
        add_in1 = '0;
        add_in2 = '0;
        add_cin = 1'b0;
        if (grant_any) begin
            add_in1 = req_a[int'(grant_idx)*W +: W];
            add_in2 = req_b[int'(grant_idx)*W +: W];
            add_cin = req_cin[grant_idx];
        end
    end

    // ------------------------------------------------------------------
    // Round-robin pointer: moves past the winner, holds when idle
    // ------------------------------------------------------------------
    always_comb begin
        ptr_next = ptr_reg;
        if (grant_any) begin
            ptr_next = (grant_idx == PTRW'(NREQ - 1)) ? '0 : grant_idx + PTRW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

    // ------------------------------------------------------------------
    // Tag pipe: LAT stages so the tail lines up with the adder output
    // ------------------------------------------------------------------
    always_comb begin
        tag_next       = '0;
        tag_next.valid = grant_any;
        tag_next.id    = IDW'(grant_idx);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) begin
                tag_reg[i] <= '0;
            end
        end else begin
            tag_reg[0] <= tag_next;
            for (int i = 1; i < LAT; i++) begin
                tag_reg[i] <= tag_reg[i-1];
            end
        end
    end

    assign tag_tail = tag_reg[LAT-1];

    // ------------------------------------------------------------------
    // Response demux: one-hot valid, result bus forced to zero when idle
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_rsp
            assign rsp_valid[gi] = tag_tail.valid && (tag_tail.id == IDW'(gi));
        end
    endgenerate

    assign rsp_sum  = tag_tail.valid ? add_sum  : '0;
    assign rsp_cout = tag_tail.valid ? add_cout : 1'b0;

endmodule

// File: tb/tb_rdcla_arbiter.sv
// Self-checking bench for rdcla_arbiter with a behavioural registered adder.
// The reference model keeps a round-robin pointer as an integer and a queue
// of expected responses tagged with the cycle they are due.
module tb_rdcla_arbiter;

    localparam int W    = 32;
    localparam int NREQ = 4;
    localparam int LAT  = 2;

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_cin;
    logic [NREQ-1:0]   rsp_valid;
    logic [W-1:0]      rsp_sum;
    logic              rsp_cout;
    logic [W-1:0]      add_in1;
    logic [W-1:0]      add_in2;
    logic              add_cin;
    logic [W-1:0]      add_sum;
    logic              add_cout;

    rdcla_arbiter #(.W(W), .NREQ(NREQ), .LAT(LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .rsp_valid (rsp_valid),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .add_in1   (add_in1),
        .add_in2   (add_in2),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_cout  (add_cout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural adder with LAT register stages
    logic [W:0] add_pipe [LAT];
    always @(posedge clk) begin
        add_pipe[0] <= {1'b0, add_in1} + {1'b0, add_in2} + {{W{1'b0}}, add_cin};
        for (int i = 1; i < LAT; i++) add_pipe[i] <= add_pipe[i-1];
    end
    assign add_sum  = add_pipe[LAT-1][W-1:0];
    assign add_cout = add_pipe[LAT-1][W];

    // ---------------- reference model ----------------
    typedef struct {
        int         id;
        logic [W:0] res;
        int         due;
    } exp_t;

    exp_t exp_q[$];
    int   m_ptr;
    int   cyc;
    int   n_checks;
    int   n_errs;

    function automatic int pick(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [W-1:0] op_a(input int i);
        return req_a[i*W +: W];
    endfunction

    function automatic logic [W-1:0] op_b(input int i);
        return req_b[i*W +: W];
    endfunction

    function automatic logic [NREQ-1:0] exp_rv();
        if (exp_q.size() > 0 && exp_q[0].due == cyc) return NREQ'(1) << exp_q[0].id;
        return '0;
    endfunction

    function automatic logic [W:0] exp_res();
        if (exp_q.size() > 0 && exp_q[0].due == cyc) return exp_q[0].res;
        return '0;
    endfunction

    function automatic logic [NREQ-1:0] exp_ready();
        int g;
        g = rst_n ? pick(req_valid, m_ptr) : -1;
        return (g < 0) ? '0 : (NREQ'(1) << g);
    endfunction

    function automatic logic [W-1:0] rand_op();
        case ($urandom % 4)
            0:       return '0;
            1:       return '1;
            default: return W'($urandom);
        endcase
    endfunction

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_cin[i]      = c;
    endtask

    task automatic reset_model();
        exp_q.delete();
        m_ptr = 0;
    endtask

    // Advance one clock edge, updating the model with the handshake (if any).
    task automatic tick();
        int   g;
        exp_t e;
        g = rst_n ? pick(req_valid, m_ptr) : -1;
        if (g >= 0) begin
            e.id  = g;
            e.res = {1'b0, op_a(g)} + {1'b0, op_b(g)} + {{W{1'b0}}, req_cin[g]};
        end
        @(posedge clk);
        cyc++;
        if (g >= 0) begin
            e.due = cyc + LAT - 1;
            exp_q.push_back(e);
            m_ptr = (g + 1) % NREQ;
            $display("grant id=%0d a=%h b=%h cin=%0d exp=%h", g, op_a(g), op_b(g), req_cin[g], e.res);
        end
        while (exp_q.size() > 0 && exp_q[0].due < cyc) void'(exp_q.pop_front());
        @(negedge clk);
    endtask

    task automatic reset_dut();
        rst_n     = 1'b0;
        req_valid = '0;
        reset_model();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = '1;
        for (int i = 0; i < NREQ; i++) set_op(i, rand_op(), rand_op(), 1'($urandom));
        reset_model();
        #1;
        n_checks++; if (req_ready !== '0) begin n_errs++; $display("FAIL reset_ready got=%b want=0", req_ready); end
        n_checks++; if (rsp_valid !== '0 || rsp_sum !== '0 || rsp_cout !== 1'b0) begin
            n_errs++; $display("FAIL reset_rsp got v=%b s=%h c=%b want 0", rsp_valid, rsp_sum, rsp_cout); end
        n_checks++; if (add_in1 !== '0 || add_in2 !== '0 || add_cin !== 1'b0) begin
            n_errs++; $display("FAIL reset_add got %h %h %b want 0", add_in1, add_in2, add_cin); end
        tick();
        n_checks++; if (rsp_valid !== '0) begin n_errs++; $display("FAIL reset_hold_rsp got=%b want=0", rsp_valid); end
        rst_n     = 1'b1;
        req_valid = 4'b1010;
        #1;
        n_checks++; if (req_ready !== 4'b0010) begin n_errs++; $display("FAIL reset_first_grant got=%b want=0010", req_ready); end
        tick();
        req_valid = '0;
        repeat (LAT + 1) tick();
    endtask

    task automatic test_single();
        reset_dut();
        req_valid = 4'b0001;
        set_op(0, 32'd33, 32'd12, 1'b0);
        #1;
        n_checks++; if (req_ready !== 4'b0001) begin n_errs++; $display("FAIL single_ready got=%b want=0001", req_ready); end
        n_checks++; if (add_in1 !== 32'd33 || add_in2 !== 32'd12 || add_cin !== 1'b0) begin
            n_errs++; $display("FAIL single_mux got %0d %0d %b want 33 12 0", add_in1, add_in2, add_cin); end
        tick();
        req_valid = '0;
        for (int t = 0; t < LAT - 1; t++) begin
            #1;
            n_checks++; if (rsp_valid !== '0) begin n_errs++; $display("FAIL single_early got=%b want=0", rsp_valid); end
            tick();
        end
        #1;
        n_checks++; if (rsp_valid !== 4'b0001 || rsp_sum !== 32'd45 || rsp_cout !== 1'b0) begin
            n_errs++; $display("FAIL single_rsp got v=%b s=%0d c=%b want 0001 45 0", rsp_valid, rsp_sum, rsp_cout); end
        tick();
        #1;
        n_checks++; if (rsp_valid !== '0 || rsp_sum !== '0) begin
            n_errs++; $display("FAIL single_after got v=%b s=%h want 0", rsp_valid, rsp_sum); end
    endtask

    task automatic test_all_valid();
        logic [W-1:0] sums  [4];
        logic         couts [4];
        sums  = '{32'd15, 32'd25, 32'd234, 32'd0};
        couts = '{1'b0, 1'b0, 1'b0, 1'b1};
        reset_dut();
        set_op(0, 32'd3, 32'd12, 1'b0);
        set_op(1, 32'd13, 32'd12, 1'b0);
        set_op(2, 32'd113, 32'd121, 1'b0);
        set_op(3, 32'hFFFF_FFFF, 32'd1, 1'b0);
        req_valid = '1;
        for (int c = 0; c < 10; c++) begin
            #1;
            n_checks++; if (req_ready !== (NREQ'(1) << (c % NREQ))) begin
                n_errs++; $display("FAIL rr_order c=%0d got=%b want=%b", c, req_ready, NREQ'(1) << (c % NREQ)); end
            if (c >= LAT) begin
                n_checks++;
                if (rsp_valid !== (NREQ'(1) << ((c - LAT) % NREQ)) || rsp_sum !== sums[(c - LAT) % NREQ]
                    || rsp_cout !== couts[(c - LAT) % NREQ]) begin
                    n_errs++; $display("FAIL rr_rsp c=%0d got v=%b s=%h c=%b want v=%b s=%h c=%b", c, rsp_valid, rsp_sum,
                        rsp_cout, NREQ'(1) << ((c - LAT) % NREQ), sums[(c - LAT) % NREQ], couts[(c - LAT) % NREQ]);
                end
            end
            tick();
        end
        req_valid = '0;
        repeat (LAT + 1) tick();
    endtask

    task automatic test_pair();
        int seen [$];
        reset_dut();
        for (int i = 0; i < NREQ; i++) set_op(i, W'(i * 100), W'(i), 1'b0);
        req_valid = 4'b0010;
        tick();
        req_valid = 4'b1010;
        #1;
        n_checks++; if (req_ready !== 4'b1000) begin n_errs++; $display("FAIL pair_first got=%b want=1000", req_ready); end
        tick();
        #1;
        n_checks++; if (req_ready !== 4'b0010) begin n_errs++; $display("FAIL pair_second got=%b want=0010", req_ready); end
        tick();
        req_valid = '0;
        #1;
        n_checks++; if (req_ready !== '0) begin n_errs++; $display("FAIL pair_idle got=%b want=0", req_ready); end
        for (int c = 0; c < LAT + 2; c++) begin
            #1;
            n_checks++; if (rsp_valid !== exp_rv() || {rsp_cout, rsp_sum} !== exp_res()) begin
                n_errs++; $display("FAIL pair_rsp got v=%b r=%h want v=%b r=%h", rsp_valid, {rsp_cout, rsp_sum}, exp_rv(), exp_res()); end
            if (rsp_valid != '0) seen.push_back($clog2(rsp_valid));
            tick();
        end
        n_checks++; if (seen.size() < 2 || seen[seen.size()-2] != 3 || seen[seen.size()-1] != 1) begin
            n_errs++; $display("FAIL pair_order got %0d responses want last two ids 3,1", seen.size()); end
    endtask

    task automatic test_cin();
        req_valid = 4'b0001;
        set_op(0, 32'hFFFF_FFFF, 32'd0, 1'b1);
        #1;
        n_checks++; if (add_cin !== 1'b1) begin n_errs++; $display("FAIL cin_mux got=%b want=1", add_cin); end
        tick();
        req_valid = '0;
        repeat (LAT - 1) tick();
        #1;
        n_checks++; if (rsp_valid !== 4'b0001 || rsp_sum !== '0 || rsp_cout !== 1'b1) begin
            n_errs++; $display("FAIL cin_rsp got v=%b s=%h c=%b want 0001 0 1", rsp_valid, rsp_sum, rsp_cout); end
        repeat (2) tick();
    endtask

    task automatic test_gaps();
        logic [NREQ-1:0] pat [3];
        int pulses;
        int others;
        pat    = '{4'b0100, 4'b0000, 4'b0100};
        pulses = 0;
        others = 0;
        set_op(2, 32'd7, 32'd8, 1'b1);
        for (int c = 0; c < 3 + LAT + 2; c++) begin
            req_valid = (c < 3) ? pat[c] : '0;
            #1;
            if (c < 3) begin
                n_checks++; if (req_ready !== pat[c]) begin
                    n_errs++; $display("FAIL gaps_ready c=%0d got=%b want=%b", c, req_ready, pat[c]); end
            end
            if (rsp_valid[2] === 1'b1) begin
                pulses++;
                n_checks++; if (rsp_sum !== 32'd16 || rsp_cout !== 1'b0) begin
                    n_errs++; $display("FAIL gaps_sum got s=%0d c=%b want 16 0", rsp_sum, rsp_cout); end
            end
            if ((rsp_valid & 4'b1011) != '0) others++;
            tick();
        end
        n_checks++; if (pulses != 2 || others != 0) begin
            n_errs++; $display("FAIL gaps_pulses got=%0d stray=%0d want 2 0", pulses, others); end
    endtask

    task automatic test_reset_midflight();
        req_valid = 4'b0100;
        set_op(2, 32'd1, 32'd2, 1'b0);
        tick();
        // handshake done; reset lands before the response emerges
        rst_n     = 1'b0;
        req_valid = '1;
        reset_model();
        #1;
        n_checks++; if (req_ready !== '0 || rsp_valid !== '0 || rsp_sum !== '0 || rsp_cout !== 1'b0) begin
            n_errs++; $display("FAIL mid_reset_out got rdy=%b v=%b s=%h c=%b want 0", req_ready, rsp_valid, rsp_sum, rsp_cout); end
        tick();
        rst_n     = 1'b1;
        req_valid = 4'b1100;
        #1;
        n_checks++; if (rsp_valid !== '0) begin n_errs++; $display("FAIL mid_dropped got=%b want=0", rsp_valid); end
        n_checks++; if (req_ready !== 4'b0100) begin n_errs++; $display("FAIL mid_first_grant got=%b want=0100", req_ready); end
        tick();
        req_valid = '0;
        for (int c = 0; c < LAT + 1; c++) begin
            #1;
            n_checks++; if (rsp_valid !== exp_rv()) begin
                n_errs++; $display("FAIL mid_drain got=%b want=%b", rsp_valid, exp_rv()); end
            tick();
        end
    endtask

    task automatic test_random();
        int g;
        for (int c = 0; c < 400; c++) begin
            req_valid = NREQ'($urandom);
            if ($urandom % 8 == 0) req_valid = '0;
            for (int i = 0; i < NREQ; i++) set_op(i, rand_op(), rand_op(), 1'($urandom));
            #1;
            g = pick(req_valid, m_ptr);
            n_checks++; if (req_ready !== exp_ready()) begin
                n_errs++; $display("FAIL rnd_ready c=%0d got=%b want=%b", c, req_ready, exp_ready()); end
            n_checks++;
            if (g < 0 ? (add_in1 !== '0 || add_in2 !== '0 || add_cin !== 1'b0)
                      : (add_in1 !== op_a(g) || add_in2 !== op_b(g) || add_cin !== req_cin[g])) begin
                n_errs++; $display("FAIL rnd_mux c=%0d g=%0d got %h %h %b", c, g, add_in1, add_in2, add_cin); end
            n_checks++; if (rsp_valid !== exp_rv() || {rsp_cout, rsp_sum} !== exp_res()) begin
                n_errs++; $display("FAIL rnd_rsp c=%0d got v=%b r=%h want v=%b r=%h", c, rsp_valid, {rsp_cout, rsp_sum},
                    exp_rv(), exp_res()); end
            tick();
        end
        req_valid = '0;
        repeat (LAT + 1) tick();
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_cin   = '0;
        n_checks  = 0;
        n_errs    = 0;
        cyc       = 0;
        reset_model();
        repeat (2) @(negedge clk);
        test_reset();
        test_single();
        test_all_valid();
        test_pair();
        test_cin();
        test_gaps();
        test_reset_midflight();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
